// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream loader and the result serializer:
// loader state encoding and flattened-matrix slot addressing.
package matrix_pkg;

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Counter width that stays at least one bit for degenerate dimensions of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // MSB of element (r,c) in the flattened word; element (0,0) sits at the top.
    function automatic int elem_msb(input int r, input int c, input int rows,
                                    input int cols, input int w);
        return rows * cols * w - (r * cols + c) * w - 1;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column position counter with wrap, synchronous clear and a
// flag marking the final slot of the matrix.
module rc_counter
    import matrix_pkg::*;
#(
    parameter int ROWS = 32,
    parameter int COLS = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [cnt_w(ROWS)-1:0]   row,
    output logic [cnt_w(COLS)-1:0]   col,
    output logic                     last_slot
);

    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    assign last_slot = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects a row-major element stream into one flattened matrix word, checks
// framing with in_last, and drops/flags undersize and oversize frames.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int ROWS       = 32,
    parameter int COLS       = 24,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] out_matrix,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err
);

    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);

    logic [1:0]    state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last_slot;
    logic          accept;
    logic          fill_beat;
    logic          frame_end;

    assign in_ready  = (state != ST_FULL);
    assign accept    = in_valid && in_ready;
    assign fill_beat = accept && (state == ST_FILL) && !flush;
    // Either a proper frame end or a framing error restarts the slot position.
    assign frame_end = fill_beat && (last_slot || in_last);

    rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush || frame_end),
        .inc       (fill_beat && !frame_end),
        .row       (row),
        .col       (col),
        .last_slot (last_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (flush) begin
            state     <= ST_FILL;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (last_slot && in_last) begin
                            state     <= ST_FULL;
                            out_valid <= 1'b1;
                        end else if (last_slot) begin
                            state <= ST_DISCARD;
                            err   <= 1'b1;
                        end else if (in_last) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (accept && in_last)
                        state <= ST_FILL;
                end
                ST_FULL: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_FILL;
                    end
                end
                default: begin
                    state     <= ST_FILL;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Per-slot decode against constant positions keeps the write path free of
    // any index multiplication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_matrix <= '0;
        end else if (fill_beat) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (row == RW'(r) && col == CW'(c))
                        out_matrix[elem_msb(r, c, ROWS, COLS, DATA_WIDTH) -: DATA_WIDTH] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader (2x3 of 8-bit elements) with a
// handshake-driven scoreboard for completed frames.
module tb_matrix_stream_loader;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int W    = 8;
    localparam int MW   = ROWS * COLS * W;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [MW-1:0] out_matrix;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    int n_checks;
    int n_fail;
    int err_cnt;
    logic [MW-1:0] exp_q[$];
    logic          err_after[16];

    matrix_stream_loader #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_matrix (out_matrix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h, required no frame", out_matrix);
            end else begin
                logic [MW-1:0] e;
                e = exp_q.pop_front();
                if (out_matrix !== e) begin
                    n_fail++;
                    $display("FAIL sb_matrix: got 0x%0h, required 0x%0h", out_matrix, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && err) err_cnt++;
    end

    // Called just after a rising edge; each beat is taken on the next edge.
    task automatic send_beats(input logic [W-1:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + W'(i);
            in_last  = (i == last_at - 1);
            @(posedge clk);
            #1;
            err_after[i] = err;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e0;
        logic stable;
        n_checks  = 0;
        n_fail    = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_matrix", 64'(out_matrix), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // 1: good frame, consumer ready
        exp_q.push_back(48'h111213141516);
        send_beats(8'h11, 6, 6);
        check("t1_out_valid_rise", 64'(out_valid), 64'd1);
        check("t1_matrix", 64'(out_matrix), 64'h111213141516);
        step(1);
        check("t1_out_valid_one_cycle", 64'(out_valid), 64'd0);
        check("t1_no_err", 64'(err_cnt), 64'd0);

        // 2: consumer back-pressure
        out_ready = 1'b0;
        exp_q.push_back(48'h313233343536);
        send_beats(8'h31, 6, 6);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(out_valid === 1'b1 && out_matrix === 48'h313233343536 && in_ready === 1'b0))
                stable = 1'b0;
            step(1);
        end
        check("t2_hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        step(1);
        check("t2_after_hs_valid", 64'(out_valid), 64'd0);
        check("t2_after_hs_in_ready", 64'(in_ready), 64'd1);

        // 3: undersize frame then good frame
        e0 = err_cnt;
        send_beats(8'h01, 4, 4);
        check("t3_err_pulse", 64'(err), 64'd1);
        check("t3_no_valid", 64'(out_valid), 64'd0);
        step(1);
        check("t3_err_one_cycle", 64'(err), 64'd0);
        check("t3_err_count", 64'(err_cnt - e0), 64'd1);
        exp_q.push_back(48'h212223242526);
        send_beats(8'h21, 6, 6);
        check("t3_good_valid", 64'(out_valid), 64'd1);
        step(1);

        // 4: oversize frame then good frame
        e0 = err_cnt;
        send_beats(8'h41, 8, 8);
        check("t4_no_err_early", 64'(err_after[4]), 64'd0);
        check("t4_err_after_6th", 64'(err_after[5]), 64'd1);
        check("t4_no_err_discard", 64'(err_after[6] | err_after[7]), 64'd0);
        check("t4_no_valid", 64'(out_valid), 64'd0);
        step(1);
        check("t4_err_count", 64'(err_cnt - e0), 64'd1);
        exp_q.push_back(48'h515253545556);
        send_beats(8'h51, 6, 6);
        check("t4_good_valid", 64'(out_valid), 64'd1);
        step(1);

        // 5: reset mid-frame
        e0 = err_cnt;
        send_beats(8'h61, 3, 0);
        rst_n = 1'b0;
        #1;
        check("t5_async_matrix", 64'(out_matrix), 64'd0);
        check("t5_async_valid", 64'(out_valid), 64'd0);
        check("t5_async_err", 64'(err), 64'd0);
        check("t5_async_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        exp_q.push_back(48'h717273747576);
        send_beats(8'h71, 6, 6);
        check("t5_good_valid", 64'(out_valid), 64'd1);
        step(1);
        check("t5_no_err", 64'(err_cnt - e0), 64'd0);

        // 6: flush while full, then flush during fill
        out_ready = 1'b0;
        send_beats(8'h81, 6, 6);
        check("t6_full_valid", 64'(out_valid), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_flush_valid", 64'(out_valid), 64'd0);
        check("t6_flush_in_ready", 64'(in_ready), 64'd1);
        check("t6_flush_matrix_kept", 64'(out_matrix), 64'h818283848586);
        out_ready = 1'b1;
        send_beats(8'h91, 2, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_flush_beat_dropped", 64'(out_matrix), 64'h919283848586);
        exp_q.push_back(48'hA1A2A3A4A5A6);
        send_beats(8'hA1, 6, 6);
        check("t6_restart_valid", 64'(out_valid), 64'd1);
        step(3);
        check("sb_queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_err_count", 64'(err_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
